// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: the J opcode, the NOP word, the fetch-stage
// state encoding, the default reset PC and helpers for decoding J in fetch.
package mips_pkg;

  localparam logic [5:0]  OP_J             = 6'b000010;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // True when the word is an unconditional J.
  function automatic logic is_j(input logic [31:0] instr);
    return instr[31:26] == OP_J;
  endfunction

  // J target: upper nibble of the delay-slot PC joined with the word index.
  function automatic logic [31:0] j_target(input logic [31:0] pc4,
                                           input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying {instr, pc4, valid} (65 bits). Flush beats stall,
// stall beats load. A flush turns the slot into a NOP with valid cleared and
// leaves pc4 untouched. Written generically so ID/EX can reuse it.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  input  logic        valid_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  // Register update: synchronous reset, then flush, hold, load in priority order.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (!stall_i && load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= valid_i;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, the imem request/ack handshake and the
// IF/ID register. Handles stalls (HOLD parks a word fetched during a stall),
// downstream redirects (DISCARD drains an outstanding request) and memory of
// any latency. Optional macro FETCH_JUMP_EN resolves J in fetch so that
// decode never sees it.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc4_q, hold_pc4_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  pc_plus4;

  logic         ifid_load;
  logic         ifid_flush;
  logic [31:0]  ifid_instr_d;
  logic [31:0]  ifid_pc4_d;

  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32

  // The request stays up in FETCH and DISCARD; the address is the PC, which
  // does not move until the ack arrives, so it is stable while waiting.
  assign imem_req  = !reset && (state_q != HOLD);
  assign imem_addr = pc_q;

  // State, PC and side registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= NOP_WORD;
      hold_pc4_q   <= '0;
      target_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      target_q     <= target_d;
    end
  end

  // Next-state, PC update and IF/ID control; redirect wins over stall everywhere.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    target_d     = target_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr_d = imem_rdata;
    ifid_pc4_d   = pc_plus4;

    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          if (imem_ack) begin
            pc_d = redirect_pc;
          end else begin
            target_d = redirect_pc;
            state_d  = DISCARD;
          end
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (stall) begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = pc_plus4;
            state_d      = HOLD;
`ifdef FETCH_JUMP_EN
            if (is_j(imem_rdata)) pc_d = j_target(pc_plus4, imem_rdata);
`endif
          end else begin
`ifdef FETCH_JUMP_EN
            if (is_j(imem_rdata)) begin
              pc_d       = j_target(pc_plus4, imem_rdata);
              ifid_flush = 1'b1;
            end else begin
              ifid_load = 1'b1;
            end
`else
            ifid_load = 1'b1;
`endif
          end
        end else if (!stall) begin
          ifid_flush = 1'b1;  // waiting on memory: push a bubble
        end
      end

      HOLD: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          pc_d       = redirect_pc;
          state_d    = FETCH;
        end else if (!stall) begin
          ifid_instr_d = hold_instr_q;
          ifid_pc4_d   = hold_pc4_q;
          state_d      = FETCH;
`ifdef FETCH_JUMP_EN
          // PC already points at the J target; the J itself becomes a NOP.
          if (is_j(hold_instr_q)) ifid_flush = 1'b1;
          else                    ifid_load  = 1'b1;
`else
          ifid_load = 1'b1;
`endif
        end
      end

      DISCARD: begin
        ifid_flush = 1'b1;
        if (redirect) target_d = redirect_pc;
        if (imem_ack) begin
          pc_d    = redirect ? redirect_pc : target_q;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .stall_i (stall),
    .flush_i (ifid_flush),
    .instr_i (ifid_instr_d),
    .pc4_i   (ifid_pc4_d),
    .valid_i (1'b1),
    .instr_o (if_id_instr),
    .pc4_o   (if_id_pc4),
    .valid_o (if_id_valid)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: the bench plays instruction memory cycle by
// cycle. Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc4"},   if_id_pc4,   pc4);
    check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
    if (req) check({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset
    tick(); tick();
    check_req("rst", 1'b0, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst.addr", imem_addr, 32'h0);
    reset = 1'b0; #1;
    check_req("rst_rel", 1'b1, 32'h0);

    // Zero-wait memory: one instruction per cycle
    imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
    tick();
    check_ifid("zw0", 32'h2001_0005, 32'h4, 1'b1);
    check_req("zw0", 1'b1, 32'h4);
    imem_rdata = 32'h0022_1820;
    tick();
    check_ifid("zw1", 32'h0022_1820, 32'h8, 1'b1);
    check_req("zw1", 1'b1, 32'h8);

    // Ack delayed two cycles: two bubbles, address stable
    imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
    tick();
    check_ifid("lat0", 32'h0, 32'h8, 1'b0);
    check_req("lat0", 1'b1, 32'h8);
    tick();
    check_ifid("lat1", 32'h0, 32'h8, 1'b0);
    check_req("lat1", 1'b1, 32'h8);
    imem_ack = 1'b1; imem_rdata = 32'h8C41_0000;
    tick();
    check_ifid("lat2", 32'h8C41_0000, 32'hC, 1'b1);
    check_req("lat2", 1'b1, 32'hC);

    // Ack during a 3-cycle stall: word parked, no request while holding
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hAC41_0004;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    check_ifid("stl0", 32'h8C41_0000, 32'hC, 1'b1);
    check_req("stl0", 1'b0, 32'h0);
    tick();
    check_req("stl1", 1'b0, 32'h0);
    check_ifid("stl1", 32'h8C41_0000, 32'hC, 1'b1);
    tick();
    check_req("stl2", 1'b0, 32'h0);
    stall = 1'b0;
    tick();
    check_ifid("stl3", 32'hAC41_0004, 32'h10, 1'b1);
    check_req("stl3", 1'b1, 32'h10);

    // Redirect to 0x40 while the request to 0x10 is outstanding
    redirect = 1'b1; redirect_pc = 32'h40; imem_ack = 1'b0;
    tick();
    redirect = 1'b0; redirect_pc = 32'h0;
    check_ifid("dis0", 32'h0, 32'h10, 1'b0);
    check_req("dis0", 1'b1, 32'h10);
    tick();
    check_ifid("dis1", 32'h0, 32'h10, 1'b0);
    check_req("dis1", 1'b1, 32'h10);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check_ifid("dis2", 32'h0, 32'h10, 1'b0);
    check_req("dis2", 1'b1, 32'h40);

    // Redirect with ack and stall both high: redirect wins, PC to 0xFFFFFFFC
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    imem_rdata = 32'h1111_1111;
    tick();
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    check_ifid("rdack", 32'h0, 32'h10, 1'b0);
    check_req("rdack", 1'b1, 32'hFFFF_FFFC);

    // PC+4 wraps to zero
    imem_rdata = 32'h0123_4567;
    tick();
    check_ifid("wrap", 32'h0123_4567, 32'h0, 1'b1);
    check_req("wrap", 1'b1, 32'h0);

    // J 0x08000010 fetched at pc 0
    imem_rdata = 32'h0800_0010;
    tick();
`ifdef FETCH_JUMP_EN
    check_ifid("jmp", 32'h0, 32'h0, 1'b0);
    check_req("jmp", 1'b1, 32'h40);
`else
    check_ifid("jmp", 32'h0800_0010, 32'h4, 1'b1);
    check_req("jmp", 1'b1, 32'h4);
`endif

    // Reset asserted while in HOLD
    stall = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_ack = 1'b0;
    check_req("rhold", 1'b0, 32'h0);
    reset = 1'b1; #1;
    check_req("rhold_rst", 1'b0, 32'h0);
    tick();
    check_req("rhold_rst1", 1'b0, 32'h0);
    check_ifid("rhold_rst1", 32'h0, 32'h0, 1'b0);
    check("rhold_rst1.pc", imem_addr, 32'h0);
    reset = 1'b0; stall = 1'b0; #1;
    check_req("rhold_rel", 1'b1, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
    tick();
    check_ifid("rhold_f", 32'h3333_3333, 32'h4, 1'b1);
    check_req("rhold_f", 1'b1, 32'h4);
    imem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
